que_sched_ctrl: RTL and testbench
=================================

QUE_SCHED_CTRL -- requirements
Module: que_sched_ctrl

Interface
REQ-001 Parameter PORTNUM, default 16, number of input ports served; SHALL be 16 to match the arbiter's 16-input priority encoder.
REQ-002 Parameter PRIOR, default 8, number of priority levels.
REQ-003 Parameter TIMEOUT, default 1024, maximum number of SERVE cycles before a forced release.
REQ-004 i_clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous active-low reset.
REQ-006 i_pending  in  PORTNUM  per-port queue non-empty flags.
REQ-007 i_prior  in  $clog2(PRIOR) x PORTNUM  per-port priority, passed through to the arbiter.
REQ-008 o_arb_update  out  1  arbiter snapshot strobe.
REQ-009 o_arb_clr_port  out  $clog2(PORTNUM)  port index to clear in the arbiter.
REQ-010 o_arb_clr_vld  out  1  arbiter clear strobe.
REQ-011 i_arb_port  in  $clog2(PORTNUM)  port selected by the arbiter.
REQ-012 i_arb_port_vld  in  1  arbiter selection valid.
REQ-013 i_arb_empty  in  1  arbiter has no pending ports.
REQ-014 o_grant_port  out  $clog2(PORTNUM)  port granted to the readout datapath.
REQ-015 o_grant_vld  out  1  grant valid.
REQ-016 i_grant_rdy  in  1  datapath accepts the grant.
REQ-017 i_done  in  1  datapath has finished serving the granted port.
REQ-018 o_timeout  out  1  one-cycle pulse when a serve is force-ended.
REQ-019 o_busy  out  1  high whenever the FSM state is not IDLE.

Function
REQ-020 The FSM SHALL use the states IDLE, UPD, WAIT, GRANT, SERVE and CLR, held in a registered state register; all outputs SHALL be registered or decoded only from registered state.
REQ-021 IDLE: when |i_pending is 1, the next state SHALL be UPD; otherwise the FSM SHALL stay in IDLE.
REQ-022 UPD: o_arb_update SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-023 WAIT: the FSM SHALL stay exactly one cycle.
  - If i_arb_empty is 1, the next state SHALL be IDLE.
  - Else if i_arb_port_vld is 1, the FSM SHALL latch i_arb_port into the grant register and go to GRANT.
  - Otherwise the next state SHALL be IDLE.
REQ-024 GRANT: o_grant_vld SHALL be 1 and o_grant_port SHALL be stable until the cycle in which i_grant_rdy is 1; the FSM SHALL then go to SERVE.
REQ-025 SERVE: a counter SHALL start from 0 and increment each cycle.
  - On i_done the next state SHALL be CLR.
  - When the count reaches TIMEOUT-1 without i_done, o_timeout SHALL pulse and the next state SHALL be CLR.
  - If i_done and the timeout coincide, i_done SHALL win and o_timeout SHALL stay 0.
REQ-026 CLR: o_arb_clr_vld SHALL be 1 for one cycle with o_arb_clr_port equal to the granted port, and the next state SHALL be WAIT; this continues the current snapshot round without a new update.
REQ-027 A new snapshot (UPD) SHALL occur only after the arbiter reports empty, so that every port in a round is served once, in the arbiter's priority order.
REQ-028 Timing: pending first seen in IDLE at cycle 0 SHALL give UPD at cycle 1, WAIT at cycle 2 and o_grant_vld=1 at cycle 3.
REQ-029 i_grant_rdy SHALL be ignored outside GRANT, and i_done SHALL be ignored outside SERVE.
REQ-030 Changes on i_pending during a round SHALL be ignored until the next UPD.
REQ-031 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide, SHALL saturate, and SHALL clear on entry to SERVE.

Reset
REQ-032 Assertion of i_rst_n SHALL, asynchronously and in any state including mid-serve, force:
  - state to IDLE;
  - the counter to 0;
  - all outputs to 0: o_arb_update, o_arb_clr_vld, o_arb_clr_port, o_grant_vld, o_grant_port, o_timeout, o_busy.
REQ-033 After reset release, the first UPD SHALL occur no earlier than the second rising edge.

Structure
REQ-034 A shared package SHALL hold the state enum type and the PORTNUM/PRIOR default constants.
REQ-035 The serve watchdog counter SHALL be a sub-module named que_sched_wdog with inputs clr and en, and output expired.

Verification
REQ-036 The bench SHALL cover at least the following directed scenarios:
  - Single port: i_pending=16'h0010, prior 3, i_grant_rdy tied 1, i_done 5 cycles after grant -> o_grant_port=4 at cycle 3, one o_arb_clr_vld with port 4, FSM back to IDLE.
  - Two ports: ports 2 and 9 pending, port 9 higher priority -> grants in order 9 then 2, exactly one o_arb_update for the round.
  - Backpressure: i_grant_rdy held 0 for 7 cycles -> o_grant_vld and o_grant_port stable for all 7 cycles.
  - Timeout: TIMEOUT=8, i_done never asserted -> o_timeout pulses once, 8 cycles after the handshake, then o_arb_clr_vld follows.
  - Collision: i_done in the same cycle as expiry -> o_timeout=0, normal clear.
  - Reset mid-SERVE -> all outputs 0 at once; a fresh round restarts from UPD.

Source files
------------

// File: rtl/que_sched_ctrl_pkg.sv
// Shared types and defaults for the queue scheduler controller.
// Holds the FSM state encoding and the port/priority default sizes.
package que_sched_ctrl_pkg;

  localparam int PORTNUM_DEF = 16;
  localparam int PRIOR_DEF   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UPD,
    ST_WAIT,
    ST_GRANT,
    ST_SERVE,
    ST_CLR
  } state_e;

endpackage

// File: rtl/que_sched_wdog.sv
// Serve watchdog: saturating cycle counter with sync clear.
// expired is high once the count has reached TIMEOUT-1.
module que_sched_wdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAXV = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != MAXV) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt >= LAST);

endmodule

// File: rtl/que_sched_ctrl.sv
// Round-based scheduler: snapshots the arbiter, then grants,
// serves and clears each selected port until the round is empty.
module que_sched_ctrl
  import que_sched_ctrl_pkg::*;
#(
  parameter int PORTNUM = PORTNUM_DEF,
  parameter int PRIOR   = PRIOR_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [PORTNUM-1:0]                 i_pending,
  input  logic [$clog2(PRIOR)*PORTNUM-1:0]   i_prior,
  output logic                               o_arb_update,
  output logic [$clog2(PORTNUM)-1:0]         o_arb_clr_port,
  output logic                               o_arb_clr_vld,
  input  logic [$clog2(PORTNUM)-1:0]         i_arb_port,
  input  logic                               i_arb_port_vld,
  input  logic                               i_arb_empty,
  output logic [$clog2(PORTNUM)-1:0]         o_grant_port,
  output logic                               o_grant_vld,
  input  logic                               i_grant_rdy,
  input  logic                               i_done,
  output logic                               o_timeout,
  output logic                               o_busy
);

  localparam int PW = $clog2(PORTNUM);

  state_e        state;
  state_e        state_nxt;
  logic [PW-1:0] grant_q;
  logic          timeout_q;
  logic          armed_q;
  logic          expired;
  logic          prior_unused;

  // Priorities go straight to the arbiter; not used here.
  assign prior_unused = ^i_prior;

  que_sched_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .clr     (state == ST_GRANT),
    .en      (state == ST_SERVE),
    .expired (expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      timeout_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      armed_q   <= 1'b1;
      timeout_q <= (state == ST_SERVE) && expired && !i_done;
      if (state == ST_WAIT && !i_arb_empty && i_arb_port_vld) begin
        grant_q <= i_arb_port;
      end
    end
  end

  // armed_q holds off the first snapshot by one edge after reset.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (armed_q && |i_pending) state_nxt = ST_UPD;
      end
      ST_UPD: begin
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_arb_empty)         state_nxt = ST_IDLE;
        else if (i_arb_port_vld) state_nxt = ST_GRANT;
        else                     state_nxt = ST_IDLE;
      end
      ST_GRANT: begin
        if (i_grant_rdy) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        if (i_done || expired) state_nxt = ST_CLR;
      end
      ST_CLR: begin
        state_nxt = ST_WAIT;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_arb_update   = (state == ST_UPD);
  assign o_arb_clr_vld  = (state == ST_CLR);
  assign o_arb_clr_port = (state == ST_CLR) ? grant_q : '0;
  assign o_grant_vld    = (state == ST_GRANT);
  assign o_grant_port   = grant_q;
  assign o_timeout      = timeout_q;
  assign o_busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_que_sched_ctrl.sv
// Directed bench for que_sched_ctrl with a behavioural arbiter.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_que_sched_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] pending;
  logic [47:0] prior;
  logic        arb_update;
  logic [3:0]  arb_clr_port;
  logic        arb_clr_vld;
  logic [3:0]  arb_port;
  logic        arb_port_vld;
  logic        arb_empty;
  logic [3:0]  grant_port;
  logic        grant_vld;
  logic        grant_rdy;
  logic        done;
  logic        timeout;
  logic        busy;

  int n_chk;
  int n_fail;
  int upd_cnt;
  int clr_cnt;
  int to_cnt;

  que_sched_ctrl #(
    .PORTNUM (16),
    .PRIOR   (8),
    .TIMEOUT (8)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pending      (pending),
    .i_prior        (prior),
    .o_arb_update   (arb_update),
    .o_arb_clr_port (arb_clr_port),
    .o_arb_clr_vld  (arb_clr_vld),
    .i_arb_port     (arb_port),
    .i_arb_port_vld (arb_port_vld),
    .i_arb_empty    (arb_empty),
    .o_grant_port   (grant_port),
    .o_grant_vld    (grant_vld),
    .i_grant_rdy    (grant_rdy),
    .i_done         (done),
    .o_timeout      (timeout),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter model: highest priority wins, lower index on ties.
  logic [15:0] snap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap <= '0;
    else if (arb_update) snap <= pending;
    else if (arb_clr_vld) snap[arb_clr_port] <= 1'b0;
  end

  always_comb begin
    logic [2:0] bp;
    arb_port_vld = 1'b0;
    arb_port     = '0;
    bp           = '0;
    for (int k = 0; k < 16; k++) begin
      if (snap[k] && (!arb_port_vld || prior[k*3 +: 3] > bp)) begin
        arb_port_vld = 1'b1;
        arb_port     = 4'(k);
        bp           = prior[k*3 +: 3];
      end
    end
    arb_empty = (snap == 16'h0);
  end

  always @(negedge clk) begin
    if (rst_n && arb_update)  upd_cnt++;
    if (rst_n && arb_clr_vld) clr_cnt++;
    if (rst_n && timeout)     to_cnt++;
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_grant(input string nm);
    int k;
    k = 0;
    while (grant_vld !== 1'b1 && k < 30) begin
      tick();
      k++;
    end
    n_chk++;
    if (grant_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL %s grant wait: grant_vld=%b required 1", nm, grant_vld);
    end
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < 30) begin
      tick();
      k++;
    end
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle wait: busy=%b required 0", nm, busy);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    pending   = '0;
    prior     = '0;
    grant_rdy = 1'b0;
    done      = 1'b0;
    repeat (2) tick();
    n_chk++;
    if ({arb_update, arb_clr_vld, arb_clr_port, grant_vld, grant_port,
         timeout, busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h required 0",
               {arb_update, arb_clr_vld, arb_clr_port, grant_vld,
                grant_port, timeout, busy});
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_port;
    int c0;
    c0 = clr_cnt;
    prior[4*3 +: 3] = 3'd3;
    grant_rdy = 1'b1;
    pending   = 16'h0010;
    tick();
    n_chk++;
    if (arb_update !== 1'b1) begin
      n_fail++;
      $display("FAIL single upd cycle1: got %b required 1", arb_update);
    end
    tick();
    n_chk++;
    if (arb_update !== 1'b0 || busy !== 1'b1 || grant_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single wait cycle2: upd=%b busy=%b gv=%b required 0 1 0",
               arb_update, busy, grant_vld);
    end
    tick();
    n_chk++;
    if (grant_vld !== 1'b1 || grant_port !== 4'd4) begin
      n_fail++;
      $display("FAIL single grant cycle3: gv=%b port=%0d required 1 4",
               grant_vld, grant_port);
    end
    pending = '0;
    repeat (5) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_chk++;
    if (arb_clr_vld !== 1'b1 || arb_clr_port !== 4'd4 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL single clr: vld=%b port=%0d to=%b required 1 4 0",
               arb_clr_vld, arb_clr_port, timeout);
    end
    repeat (2) tick();
    n_chk++;
    if (busy !== 1'b0 || clr_cnt - c0 !== 1) begin
      n_fail++;
      $display("FAIL single end: busy=%b clears=%0d required 0 1",
               busy, clr_cnt - c0);
    end
  endtask

  task automatic test_two_ports;
    int u0;
    int c0;
    logic [3:0] g[2];
    u0 = upd_cnt;
    c0 = clr_cnt;
    prior = '0;
    prior[2*3 +: 3] = 3'd1;
    prior[9*3 +: 3] = 3'd5;
    grant_rdy = 1'b1;
    pending = 16'h0204;
    for (int i = 0; i < 2; i++) begin
      wait_grant("two");
      g[i] = grant_port;
      pending = '0;
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    wait_idle("two");
    n_chk++;
    if (g[0] !== 4'd9 || g[1] !== 4'd2) begin
      n_fail++;
      $display("FAIL two order: got %0d,%0d required 9,2", g[0], g[1]);
    end
    n_chk++;
    if (upd_cnt - u0 !== 1 || clr_cnt - c0 !== 2) begin
      n_fail++;
      $display("FAIL two counts: upd=%0d clr=%0d required 1 2",
               upd_cnt - u0, clr_cnt - c0);
    end
  endtask

  task automatic test_backpressure;
    prior = '0;
    grant_rdy = 1'b0;
    pending = 16'h0100;
    wait_grant("bp");
    pending = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_chk++;
      if (grant_vld !== 1'b1 || grant_port !== 4'd8) begin
        n_fail++;
        $display("FAIL bp hold %0d: gv=%b port=%0d required 1 8",
                 i, grant_vld, grant_port);
      end
    end
    grant_rdy = 1'b1;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_chk++;
    if (arb_clr_vld !== 1'b1 || arb_clr_port !== 4'd8) begin
      n_fail++;
      $display("FAIL bp clr: vld=%b port=%0d required 1 8",
               arb_clr_vld, arb_clr_port);
    end
    wait_idle("bp");
  endtask

  task automatic test_timeout;
    int t0;
    int early;
    t0 = to_cnt;
    early = 0;
    grant_rdy = 1'b1;
    pending = 16'h0020;
    wait_grant("to");
    pending = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (timeout !== 1'b0 || arb_clr_vld !== 1'b0) early++;
    end
    n_chk++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL to early: %0d early cycles required 0", early);
    end
    tick();
    n_chk++;
    if (timeout !== 1'b1 || arb_clr_vld !== 1'b1 || arb_clr_port !== 4'd5) begin
      n_fail++;
      $display("FAIL to pulse: to=%b clr=%b port=%0d required 1 1 5",
               timeout, arb_clr_vld, arb_clr_port);
    end
    wait_idle("to");
    n_chk++;
    if (to_cnt - t0 !== 1) begin
      n_fail++;
      $display("FAIL to count: got %0d required 1", to_cnt - t0);
    end
  endtask

  task automatic test_collision;
    int t0;
    t0 = to_cnt;
    grant_rdy = 1'b1;
    pending = 16'h0040;
    wait_grant("col");
    pending = '0;
    repeat (8) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_chk++;
    if (arb_clr_vld !== 1'b1 || timeout !== 1'b0 || arb_clr_port !== 4'd6) begin
      n_fail++;
      $display("FAIL col clr: clr=%b to=%b port=%0d required 1 0 6",
               arb_clr_vld, timeout, arb_clr_port);
    end
    wait_idle("col");
    n_chk++;
    if (to_cnt - t0 !== 0) begin
      n_fail++;
      $display("FAIL col count: got %0d required 0", to_cnt - t0);
    end
  endtask

  task automatic test_reset_mid_serve;
    grant_rdy = 1'b1;
    pending = 16'h0008;
    wait_grant("rst");
    repeat (2) tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({arb_update, arb_clr_vld, arb_clr_port, grant_vld, grant_port,
         timeout, busy} !== 13'h0) begin
      n_fail++;
      $display("FAIL rst async outputs: got %h required 0",
               {arb_update, arb_clr_vld, arb_clr_port, grant_vld,
                grant_port, timeout, busy});
    end
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    n_chk++;
    if (busy !== 1'b0 || arb_update !== 1'b0) begin
      n_fail++;
      $display("FAIL rst first edge: busy=%b upd=%b required 0 0",
               busy, arb_update);
    end
    tick();
    n_chk++;
    if (arb_update !== 1'b1) begin
      n_fail++;
      $display("FAIL rst restart upd: got %b required 1", arb_update);
    end
    wait_grant("rst2");
    n_chk++;
    if (grant_port !== 4'd3) begin
      n_fail++;
      $display("FAIL rst regrant: port=%0d required 3", grant_port);
    end
    pending = '0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    wait_idle("rst");
  endtask

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    upd_cnt = 0;
    clr_cnt = 0;
    to_cnt  = 0;
    test_reset();
    test_single_port();
    test_two_ports();
    test_backpressure();
    test_timeout();
    test_collision();
    test_reset_mid_serve();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
